// File: rtl/fsm_step_ctrl.sv
// Step controller for the 3-bit board-demo sequence counter: arbitrates next/prev buttons and an auto-advance timer.
// Optional per-button debounce is compiled in with `define FSM_STEP_DEBOUNCE_EN.
module fsm_step_ctrl #(
    parameter int unsigned AUTO_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic       hold,
    output logic [2:0] state_o,
    output logic       step_o,
    output logic       dir_o,
    output logic       wrap_o,
    output logic [1:0] mode_o
);

    localparam int unsigned PS_W = $clog2(AUTO_DIV);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_PAUSE  = 2'b10;

    if (AUTO_DIV < 2 || DEBOUNCE_CYC < 1) begin : g_bad_param
        $error("fsm_step_ctrl: AUTO_DIV must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    // Bit 0 carries the next button, bit 1 the prev button.
    logic [1:0]      sync1_q, sync2_q, prev_q, armed_q, armed_d, vld_q, lvl, req;
    logic [1:0]      mode_q, mode_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [2:0]      state_q, state_d;
    logic            step_q, step_d, dir_q, dir_d, wrap_q, wrap_d;
    logic            tick, go_step, go_fwd;

`ifdef FSM_STEP_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]      stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    // A new level is accepted once it has differed from the accepted one for DEBOUNCE_CYC cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign lvl = stable_q;
`else
    assign lvl = sync2_q;
`endif

    // Next-state, arbitration and output logic.
    always_comb begin
        mode_d  = mode_q;
        ps_d    = ps_q;
        state_d = state_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        go_step = 1'b0;
        go_fwd  = 1'b1;

        // A button held through reset stays disarmed until it is seen low after the synchronizer refills.
        armed_d = armed_q | ({2{vld_q[1]}} & ~sync2_q);
        req     = lvl & ~prev_q & armed_q;

        unique case ({auto_en, hold})
            2'b10:   mode_d = MODE_AUTO;
            2'b11:   mode_d = MODE_PAUSE;
            default: mode_d = MODE_MANUAL;
        endcase

        tick = (mode_q == MODE_AUTO) && (ps_q == PS_W'(AUTO_DIV - 1));

        case (mode_q)
            MODE_AUTO:  ps_d = tick ? '0 : ps_q + PS_W'(1);
            MODE_PAUSE: ps_d = ps_q;
            default:    ps_d = '0;
        endcase

        if (req == 2'b11) begin
            go_step = 1'b0;
        end else if (req != 2'b00) begin
            go_step = 1'b1;
            go_fwd  = req[0];
            ps_d    = '0;
        end else if (tick) begin
            go_step = 1'b1;
            go_fwd  = 1'b1;
        end

        if (go_step) begin
            step_d  = 1'b1;
            dir_d   = go_fwd;
            state_d = go_fwd ? state_q + 3'd1 : state_q - 3'd1;
            wrap_d  = go_fwd ? (state_q == 3'd7) : (state_q == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            vld_q   <= '0;
            mode_q  <= MODE_MANUAL;
            ps_q    <= '0;
            state_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            sync1_q <= {btn_prev, btn_next};
            sync2_q <= sync1_q;
            prev_q  <= lvl;
            armed_q <= armed_d;
            vld_q   <= {vld_q[0], 1'b1};
            mode_q  <= mode_d;
            ps_q    <= ps_d;
            state_q <= state_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign state_o = state_q;
    assign step_o  = step_q;
    assign dir_o   = dir_q;
    assign wrap_o  = wrap_q;
    assign mode_o  = mode_q;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Directed bench for fsm_step_ctrl (AUTO_DIV=4); debounce scenarios run when FSM_STEP_DEBOUNCE_EN is defined.
module tb_fsm_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] state_o;
    logic       step_o, dir_o, wrap_o;
    logic [1:0] mode_o;

    int n_vec = 0;
    int n_err = 0;

    fsm_step_ctrl #(.AUTO_DIV(4), .DEBOUNCE_CYC(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .auto_en  (auto_en),
        .hold     (hold),
        .state_o  (state_o),
        .step_o   (step_o),
        .dir_o    (dir_o),
        .wrap_o   (wrap_o),
        .mode_o   (mode_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step_o && n < max);
    endtask

    task automatic count_steps(input int ncyc, output int n);
        n = 0;
        repeat (ncyc) begin
            cyc();
            if (step_o) n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " state"}, 32'(state_o), 0);
        chk({tag, " step"},  32'(step_o),  0);
        chk({tag, " wrap"},  32'(wrap_o),  0);
        chk({tag, " dir"},   32'(dir_o),   1);
        chk({tag, " mode"},  32'(mode_o),  0);
    endtask

    // Press one button for 3 cycles; the step must appear exactly 2 cycles after the press is sampled.
    task automatic press_check(input bit is_next, input int es, input int ew, input int ed);
        if (is_next) btn_next = 1'b1; else btn_prev = 1'b1;
        cyc();
        chk("lat0 step", 32'(step_o), 0);
        cyc();
        chk("lat1 step", 32'(step_o), 0);
        cyc();
        chk("press step", 32'(step_o), 1);
        chk("press state", 32'(state_o), 32'(es));
        chk("press wrap", 32'(wrap_o), 32'(ew));
        chk("press dir", 32'(dir_o), 32'(ed));
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc();
        chk("pulse end step", 32'(step_o), 0);
        chk("pulse end wrap", 32'(wrap_o), 0);
        repeat (3) cyc();
    endtask

    initial begin
        int n;
        repeat (2) cyc();
        check_reset_vals("reset");
        rst_n = 1'b1;
        cyc();
`ifdef FSM_STEP_DEBOUNCE_EN
        // Short glitch is ignored; long press yields one step.
        btn_next = 1'b1;
        repeat (5) cyc();
        btn_next = 1'b0;
        count_steps(40, n);
        chk("db glitch steps", 32'(n), 0);
        btn_next = 1'b1;
        count_steps(30, n);
        btn_next = 1'b0;
        begin
            int m;
            count_steps(40, m);
            n += m;
        end
        chk("db press steps", 32'(n), 1);
        chk("db press state", 32'(state_o), 1);
        btn_prev = 1'b1;
        count_steps(30, n);
        btn_prev = 1'b0;
        chk("db prev steps", 32'(n), 1);
        chk("db prev state", 32'(state_o), 0);
        chk("db prev dir", 32'(dir_o), 0);
        repeat (40) cyc();
`else
        // Nine next presses: 1..7,0,1 with wrap only on 7->0.
        for (int i = 1; i <= 9; i++) begin
            press_check(1'b1, i % 8, (i == 8) ? 1 : 0, 1);
        end
        btn_next = 1'b1;
        count_steps(12, n);
        btn_next = 1'b0;
        chk("held steps", 32'(n), 1);
        chk("held state", 32'(state_o), 2);
        repeat (4) cyc();
        press_check(1'b0, 1, 0, 0);
        press_check(1'b0, 0, 0, 0);
        press_check(1'b0, 7, 1, 0);
        press_check(1'b1, 0, 1, 1);

        // Auto-advance every 4 cycles, pause, resume.
        auto_en = 1'b1;
        cyc();
        chk("auto mode", 32'(mode_o), 1);
        for (int i = 1; i <= 3; i++) begin
            wait_step(20, n);
            chk("auto period", 32'(n), 4);
            chk("auto state", 32'(state_o), 32'(i));
        end
        hold = 1'b1;
        count_steps(10, n);
        chk("pause steps", 32'(n), 0);
        chk("pause mode", 32'(mode_o), 2);
        hold = 1'b0;
        wait_step(20, n);
        chk("resume delay", 32'(n), 4);
        chk("resume state", 32'(state_o), 4);

        // Manual request coinciding with an auto tick: single step, prescaler restarts.
        cyc();
        btn_next = 1'b1;
        wait_step(20, n);
        chk("coin delay", 32'(n), 3);
        chk("coin state", 32'(state_o), 5);
        btn_next = 1'b0;
        wait_step(20, n);
        chk("coin next auto", 32'(n), 4);
        chk("coin next state", 32'(state_o), 6);
        btn_next = 1'b1;
        wait_step(20, n);
        chk("mid press delay", 32'(n), 3);
        chk("mid press state", 32'(state_o), 7);
        btn_next = 1'b0;
        wait_step(20, n);
        chk("ps cleared delay", 32'(n), 4);
        chk("ps cleared state", 32'(state_o), 0);
        chk("ps cleared wrap", 32'(wrap_o), 1);

        // Both buttons together: dropped.
        auto_en = 1'b0;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        count_steps(8, n);
        chk("both steps", 32'(n), 0);
        chk("both state", 32'(state_o), 0);
        chk("both mode", 32'(mode_o), 0);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (4) cyc();
        press_check(1'b0, 7, 1, 0);
        press_check(1'b0, 6, 0, 0);
        press_check(1'b0, 5, 0, 0);

        // Reset in AUTO with a button held through it.
        auto_en = 1'b1;
        cyc();
        chk("pre-reset mode", 32'(mode_o), 1);
        rst_n = 1'b0;
        btn_next = 1'b1;
        cyc();
        check_reset_vals("mid reset");
        rst_n = 1'b1;
        cyc();
        chk("post reset mode", 32'(mode_o), 1);
        auto_en = 1'b0;
        count_steps(8, n);
        chk("held thru reset steps", 32'(n), 0);
        chk("held thru reset state", 32'(state_o), 0);
        btn_next = 1'b0;
        repeat (4) cyc();
        press_check(1'b1, 1, 0, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
